// File: rtl/pipe_stim_checker.sv
// pipe_stim_checker: drives an LFSR bit stream into a single-bit register
// pipeline and checks the returned stream against a delayed local copy.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           one-cycle run request (honoured in IDLE/DONE only)
//   resp_in         pipeline output under test
//   stim_out        pipeline input stimulus
//   busy            high while filling/checking
//   done, pass      run complete / run complete with no mismatches
//   err_count       saturating mismatch count of this run
//   first_err_idx   check index of the first mismatch, 0 if none
module pipe_stim_checker #(
  parameter int       LATENCY  = 4,
  parameter bit       INVERT   = 1'b0,
  parameter int       NUM_BITS = 256,
  parameter bit [7:0] SEED     = 8'hA5,
  parameter int       ERR_W    = 8,
  parameter int       IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_in,
  output logic             stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int CNT_W = $clog2(LATENCY + NUM_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [LATENCY-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic run;
  logic stim;
  logic mism;
  logic fb;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    done_d  = done_q;
    pass_d  = pass_q;

    run  = (state_q == S_FILL) || (state_q == S_CHECK);
    stim = run & lfsr_q[7];
    fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    mism = resp_in ^ exp_q[LATENCY-1] ^ INVERT;

    // Shift written as a shift-or so LATENCY=1 needs no special case.
    exp_d = (exp_q << 1) | LATENCY'(stim);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FILL;
          lfsr_d  = SEED;
          cnt_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_FILL: begin
        lfsr_d = {lfsr_q[6:0], fb};
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        lfsr_d = {lfsr_q[6:0], fb};
        if (mism) begin
          // err_q only leaves zero on a mismatch and never returns,
          // so zero marks "no mismatch yet in this run".
          if (err_q == '0) idx_d = IDX_W'(cnt_q);
          if (err_q != '1) err_d = err_q + 1'b1;
        end
        if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      exp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign stim_out      = stim;
  assign busy          = run;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = idx_q;

endmodule

// File: tb/tb_pipe_stim_checker.sv
// Testbench for pipe_stim_checker: three instances (plain, inverting,
// 4-bit error counter) run side by side against a reference model.
module tb_pipe_stim_checker;

  localparam int L = 4;
  localparam int N = 256;

  logic clk;
  logic rst;
  logic start;

  logic resp_a, stim_a, busy_a, done_a, pass_a;
  logic [7:0] err_a, idx_a;
  logic resp_i, stim_i, busy_i, done_i, pass_i;
  logic [7:0] err_i, idx_i;
  logic resp_e, stim_e, busy_e, done_e, pass_e;
  logic [3:0] err_e;
  logic [7:0] idx_e;

  logic [4:0] pa;
  logic [3:0] pi;
  logic dly5;
  logic flip_a;
  logic inv_i;

  int n_assert = 0;
  int n_fail   = 0;

  bit bits [0:L+N-1];
  bit mask_a [0:N-1];

  int ea_err, ea_idx, ei_err, ei_idx, ee_err, ee_idx;

  pipe_stim_checker u_a (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_a),
    .stim_out(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_idx(idx_a)
  );

  pipe_stim_checker #(.INVERT(1'b1)) u_i (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_i),
    .stim_out(stim_i), .busy(busy_i), .done(done_i), .pass(pass_i),
    .err_count(err_i), .first_err_idx(idx_i)
  );

  pipe_stim_checker #(.ERR_W(4)) u_e (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_e),
    .stim_out(stim_e), .busy(busy_e), .done(done_e), .pass(pass_e),
    .err_count(err_e), .first_err_idx(idx_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pipelines being checked.
  always @(posedge clk) begin
    pa <= {pa[3:0], stim_a};
    pi <= {pi[2:0], stim_i};
  end

  assign resp_a = (dly5 ? pa[4] : pa[3]) ^ flip_a;
  assign resp_i = pi[3] ^ inv_i;
  assign resp_e = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stimulus stream from the LFSR rule, one bit per busy cycle.
  task automatic gen_bits();
    logic [7:0] q;
    logic f;
    q = 8'hA5;
    for (int n = 0; n < L + N; n++) begin
      bits[n] = q[7];
      f = q[7] ^ q[5] ^ q[4] ^ q[3];
      q = {q[6:0], f};
    end
  endtask

  // Expected results from the response each checker will see.
  task automatic predict();
    bit r;
    bit m;
    ea_err = 0; ea_idx = 0;
    ei_err = 0; ei_idx = 0;
    ee_err = 0; ee_idx = 0;
    for (int k = 0; k < N; k++) begin
      if (dly5) r = (k == 0) ? 1'b0 : bits[k-1];
      else r = bits[k];
      r = r ^ mask_a[k];
      if (r != bits[k]) begin
        if (ea_err == 0) ea_idx = k;
        if (ea_err < 255) ea_err++;
      end
      m = (bits[k] ^ inv_i) == bits[k];
      if (m) begin
        if (ei_err == 0) ei_idx = k;
        if (ei_err < 255) ei_err++;
      end
      if (bits[k]) begin
        if (ee_err == 0) ee_idx = k;
        if (ee_err < 15) ee_err++;
      end
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " stim_a"}, stim_a, 0);
    chk({nm, " busy_a"}, busy_a, 0);
    chk({nm, " done_a"}, done_a, 0);
    chk({nm, " pass_a"}, pass_a, 0);
    chk({nm, " err_a"}, err_a, 0);
    chk({nm, " idx_a"}, idx_a, 0);
    chk({nm, " busy_i"}, busy_i, 0);
    chk({nm, " err_i"}, err_i, 0);
    chk({nm, " done_e"}, done_e, 0);
    chk({nm, " err_e"}, err_e, 0);
  endtask

  task automatic run_chk(input string nm, input int mid_start,
                         input int abort_k);
    predict();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < L + N; n++) begin
      flip_a = (n >= L) ? mask_a[n-L] : 1'b0;
      start  = (n == L + mid_start);
      chk({nm, " busy"}, busy_a, 1);
      chk({nm, " stim"}, stim_a, bits[n]);
      if (abort_k >= 0 && n == L + abort_k) begin
        rst = 1'b1;
        start = 1'b0;
        flip_a = 1'b0;
        #1;
        check_zero({nm, " abort"});
        return;
      end
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    flip_a = 1'b0;
    chk({nm, " end busy"}, busy_a, 0);
    chk({nm, " done_a"}, done_a, 1);
    chk({nm, " pass_a"}, pass_a, ea_err == 0);
    chk({nm, " err_a"}, err_a, ea_err);
    chk({nm, " idx_a"}, idx_a, ea_idx);
    chk({nm, " done_i"}, done_i, 1);
    chk({nm, " pass_i"}, pass_i, ei_err == 0);
    chk({nm, " err_i"}, err_i, ei_err);
    chk({nm, " idx_i"}, idx_i, ei_idx);
    chk({nm, " pass_e"}, pass_e, ee_err == 0);
    chk({nm, " err_e"}, err_e, ee_err);
    chk({nm, " idx_e"}, idx_e, ee_idx);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " hold done"}, done_a, 1);
    chk({nm, " hold err"}, err_a, ea_err);
    chk({nm, " hold idx"}, idx_a, ea_idx);
    chk({nm, " hold busy"}, busy_a, 0);
  endtask

  task automatic clear_mask();
    for (int k = 0; k < N; k++) mask_a[k] = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    dly5   = 1'b0;
    flip_a = 1'b0;
    inv_i  = 1'b1;
    pa     = '0;
    pi     = '0;
    gen_bits();
    clear_mask();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean loopback; inverting checker sees an inverter.
    run_chk("loop", -1, -1);

    // Two flipped responses; inverting checker sees no inverter.
    mask_a[10] = 1'b1;
    mask_a[11] = 1'b1;
    inv_i = 1'b0;
    run_chk("flip", -1, -1);

    // Random flips plus a start pulse in the middle of CHECK.
    clear_mask();
    for (int k = 0; k < N; k++)
      mask_a[k] = ($urandom_range(0, 15) == 0);
    inv_i = 1'b1;
    run_chk("rand", 50, -1);

    // One stage too many in the loop.
    clear_mask();
    dly5 = 1'b1;
    run_chk("dly5", -1, -1);
    chk("dly5 some err", err_a != 0, 1);

    // Reset in the middle of CHECK, then a clean run.
    dly5 = 1'b0;
    run_chk("abort", -1, 100);
    repeat (3) @(posedge clk);
    #1;
    check_zero("abort held");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_chk("rerun", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
